// File: rtl/i2c_reg_slave_pkg.sv
// Shared definitions for the I2C register target: FSM state encoding and
// the bit-level constants used on the open-drain SDA line.
package i2c_reg_slave_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_ACK
    } state_t;

    localparam logic ACK         = 1'b0;
    localparam logic NACK        = 1'b1;
    localparam logic SDA_RELEASE = 1'b1;
    localparam logic SDA_DRIVE   = 1'b0;

    // Open-drain: a 1 on the wire is produced by letting go of it.
    function automatic logic bit_to_sda(input logic b);
        return b ? SDA_RELEASE : SDA_DRIVE;
    endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizes the asynchronous SCL/SDA pads and derives one-clk pulses for
// SCL edges and bus START/STOP conditions.
module i2c_line_sync #(
    parameter int c_sync_stages = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_sync,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    localparam int c_last = c_sync_stages - 1;

    logic [c_sync_stages-1:0] scl_pipe_reg;
    logic [c_sync_stages-1:0] sda_pipe_reg;
    logic [c_sync_stages-1:0] scl_pipe_next;
    logic [c_sync_stages-1:0] sda_pipe_next;
    logic                     scl_prev_reg;
    logic                     sda_prev_reg;
    logic                     scl_now;
    logic                     sda_now;

    genvar gi;
    generate
        for (gi = 0; gi < c_sync_stages; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign scl_pipe_next[gi] = scl_i;
                assign sda_pipe_next[gi] = sda_i;
            end else begin : g_rest
                assign scl_pipe_next[gi] = scl_pipe_reg[gi-1];
                assign sda_pipe_next[gi] = sda_pipe_reg[gi-1];
            end
        end
    endgenerate

    // Idle bus level is high, so reset everything to 1 to avoid fake edges.
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_pipe_reg <= '1;
            sda_pipe_reg <= '1;
            scl_prev_reg <= 1'b1;
            sda_prev_reg <= 1'b1;
        end else begin
            scl_pipe_reg <= scl_pipe_next;
            sda_pipe_reg <= sda_pipe_next;
            scl_prev_reg <= scl_pipe_reg[c_last];
            sda_prev_reg <= sda_pipe_reg[c_last];
        end
    end

    assign scl_now  = scl_pipe_reg[c_last];
    assign sda_now  = sda_pipe_reg[c_last];
    assign sda_sync = sda_now;
    assign scl_rise = scl_now & ~scl_prev_reg;
    assign scl_fall = ~scl_now & scl_prev_reg;
    // SCL must be high in both samples, so an SDA change coincident with an
    // SCL edge is treated as data rather than START/STOP.
    assign start = scl_now & scl_prev_reg & sda_prev_reg & ~sda_now;
    assign stop  = scl_now & scl_prev_reg & ~sda_prev_reg & sda_now;

endmodule

// File: rtl/i2c_reg_slave.sv
// I2C target exposing a byte-addressed register window: device address,
// register pointer, then write data or auto-incrementing read data.
module i2c_reg_slave
    import i2c_reg_slave_pkg::*;
#(
    parameter logic [6:0] c_dev_addr    = 7'h42,
    parameter int         c_addr_bits   = 8,
    parameter int         c_sync_stages = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   scl_i,
    input  logic                   sda_i,
    output logic                   sda_t,
    output logic                   wr,
    output logic [c_addr_bits-1:0] addr,
    input  logic [7:0]             data_in,
    output logic [7:0]             data_out,
    output logic                   busy
);

    localparam logic [c_addr_bits-1:0] c_addr_one = 1;

    logic sda_sync;
    logic scl_rise;
    logic scl_fall;
    logic start;
    logic stop;

    i2c_line_sync #(
        .c_sync_stages(c_sync_stages)
    ) u_line_sync (
        .clk     (clk),
        .reset   (reset),
        .scl_i   (scl_i),
        .sda_i   (sda_i),
        .sda_sync(sda_sync),
        .scl_rise(scl_rise),
        .scl_fall(scl_fall),
        .start   (start),
        .stop    (stop)
    );

    state_t                 state_reg,     state_next;
    logic [2:0]             bit_cnt_reg,   bit_cnt_next;
    logic [7:0]             shift_reg,     shift_next;
    logic [c_addr_bits-1:0] addr_reg,      addr_next;
    logic [7:0]             data_out_reg,  data_out_next;
    logic                   wr_reg,        wr_next;
    logic                   sda_t_reg,     sda_t_next;
    logic                   busy_reg,      busy_next;
    logic                   rw_reg,        rw_next;
    // Set on the SCL rise inside an ACK slot; separates the fall that opens
    // the slot from the fall that closes it.
    logic                   ack_phase_reg, ack_phase_next;
    logic [7:0]             rx_byte;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            bit_cnt_reg   <= 3'd0;
            shift_reg     <= 8'd0;
            addr_reg      <= '0;
            data_out_reg  <= 8'd0;
            wr_reg        <= 1'b0;
            sda_t_reg     <= SDA_RELEASE;
            busy_reg      <= 1'b0;
            rw_reg        <= 1'b0;
            ack_phase_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            bit_cnt_reg   <= bit_cnt_next;
            shift_reg     <= shift_next;
            addr_reg      <= addr_next;
            data_out_reg  <= data_out_next;
            wr_reg        <= wr_next;
            sda_t_reg     <= sda_t_next;
            busy_reg      <= busy_next;
            rw_reg        <= rw_next;
            ack_phase_reg <= ack_phase_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        bit_cnt_next   = bit_cnt_reg;
        shift_next     = shift_reg;
        addr_next      = addr_reg;
        data_out_next  = data_out_reg;
        wr_next        = 1'b0;
        sda_t_next     = sda_t_reg;
        busy_next      = busy_reg;
        rw_next        = rw_reg;
        ack_phase_next = ack_phase_reg;
        rx_byte        = {shift_reg[6:0], sda_sync};

        if (start) begin
            state_next   = ST_ADDR;
            bit_cnt_next = 3'd0;
            sda_t_next   = SDA_RELEASE;
        end else if (stop) begin
            state_next = ST_IDLE;
            sda_t_next = SDA_RELEASE;
            busy_next  = 1'b0;
        end else if (scl_rise) begin
            case (state_reg)
                ST_ADDR, ST_PTR, ST_WDATA: begin
                    shift_next     = rx_byte;
                    bit_cnt_next   = bit_cnt_reg + 3'd1;
                    ack_phase_next = 1'b0;
                    if (bit_cnt_reg == 3'd7) begin
                        if (state_reg == ST_ADDR) begin
                            if (rx_byte[7:1] == c_dev_addr) begin
                                state_next = ST_ADDR_ACK;
                                rw_next    = rx_byte[0];
                                busy_next  = 1'b1;
                            end else begin
                                state_next = ST_IDLE;
                                busy_next  = 1'b0;
                            end
                        end else if (state_reg == ST_PTR) begin
                            addr_next  = c_addr_bits'(rx_byte);
                            state_next = ST_PTR_ACK;
                        end else begin
                            data_out_next = rx_byte;
                            wr_next       = 1'b1;
                            state_next    = ST_WDATA_ACK;
                        end
                    end
                end
                ST_RDATA: begin
                    bit_cnt_next = bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == 3'd7) begin
                        state_next     = ST_RDATA_ACK;
                        ack_phase_next = 1'b0;
                    end
                end
                ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
                    ack_phase_next = 1'b1;
                end
                ST_RDATA_ACK: begin
                    ack_phase_next = 1'b1;
                    if (sda_sync == NACK) begin
                        state_next = ST_IDLE;
                        busy_next  = 1'b0;
                        sda_t_next = SDA_RELEASE;
                    end else begin
                        addr_next = addr_reg + c_addr_one;
                    end
                end
                default: ;
            endcase
        end else if (scl_fall) begin
            case (state_reg)
                ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
                    if (!ack_phase_reg) begin
                        sda_t_next = bit_to_sda(ACK);
                    end else begin
                        bit_cnt_next = 3'd0;
                        sda_t_next   = SDA_RELEASE;
                        if (state_reg == ST_ADDR_ACK && rw_reg) begin
                            state_next = ST_RDATA;
                            shift_next = data_in;
                            sda_t_next = bit_to_sda(data_in[7]);
                        end else if (state_reg == ST_ADDR_ACK) begin
                            state_next = ST_PTR;
                        end else if (state_reg == ST_PTR_ACK) begin
                            state_next = ST_WDATA;
                        end else begin
                            state_next = ST_WDATA;
                            addr_next  = addr_reg + c_addr_one;
                        end
                    end
                end
                ST_RDATA: begin
                    shift_next = {shift_reg[6:0], 1'b0};
                    sda_t_next = bit_to_sda(shift_reg[6]);
                end
                ST_RDATA_ACK: begin
                    if (!ack_phase_reg) begin
                        sda_t_next = SDA_RELEASE;
                    end else begin
                        state_next   = ST_RDATA;
                        bit_cnt_next = 3'd0;
                        shift_next   = data_in;
                        sda_t_next   = bit_to_sda(data_in[7]);
                    end
                end
                default: ;
            endcase
        end
    end

    assign sda_t    = sda_t_reg;
    assign wr       = wr_reg;
    assign addr     = addr_reg;
    assign data_out = data_out_reg;
    assign busy     = busy_reg;

endmodule

// File: tb/tb_i2c_reg_slave.sv
// Directed bench for i2c_reg_slave: a bit-banged I2C master plus a register
// RAM model; write strobes are checked by a monitor against a queue.
module tb_i2c_reg_slave;

    localparam int Q = 8;  // quarter SCL period in clk cycles

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] d;
    } wr_exp_t;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_line;
    logic       sda_t;
    logic       wr;
    logic       busy;
    logic [7:0] addr;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic [7:0] ram [256];

    int         n_checks  = 0;
    int         n_fail    = 0;
    int         drive_cnt = 0;
    wr_exp_t    exp_wr_q[$];
    logic [7:0] exp_rd_q[$];

    assign sda_line = sda_m & sda_t;

    always #20 clk = ~clk;

    always @(posedge clk) data_in <= ram[addr];

    always @(negedge clk) if (sda_t === 1'b0) drive_cnt++;

    i2c_reg_slave dut (
        .clk     (clk),
        .reset   (reset),
        .scl_i   (scl_m),
        .sda_i   (sda_line),
        .sda_t   (sda_t),
        .wr      (wr),
        .addr    (addr),
        .data_in (data_in),
        .data_out(data_out),
        .busy    (busy)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
        end
    endtask

    // Write-strobe monitor: every wr pulse must match the next queued write.
    wr_exp_t wr_e;
    always @(negedge clk) begin
        if (!reset && wr === 1'b1) begin
            if (exp_wr_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_wr: got addr=0x%02h data=0x%02h, expected no write", addr, data_out);
            end else begin
                wr_e = exp_wr_q.pop_front();
                check("wr_addr", addr, wr_e.a);
                check("wr_data", data_out, wr_e.d);
                $display("wr observed addr=0x%02h data=0x%02h", addr, data_out);
            end
        end
    end

    task automatic qwait();
        repeat (Q) @(negedge clk);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; qwait();
        scl_m = 1'b1; qwait();
        sda_m = 1'b0; qwait();
        scl_m = 1'b0; qwait();
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; qwait();
        scl_m = 1'b1; qwait();
        sda_m = 1'b1; qwait();
        qwait();
    endtask

    task automatic put_bit(input logic b);
        sda_m = b;    qwait();
        scl_m = 1'b1; qwait(); qwait();
        scl_m = 1'b0; qwait();
    endtask

    task automatic get_bit(output logic b);
        sda_m = 1'b1; qwait();
        scl_m = 1'b1; qwait();
        b = sda_line; qwait();
        scl_m = 1'b0; qwait();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic exp_ack, input string name);
        logic a;
        for (int i = 7; i >= 0; i--) put_bit(b[i]);
        get_bit(a);
        check(name, {7'd0, a}, {7'd0, exp_ack});
    endtask

    task automatic recv_byte(input logic master_ack, input string name);
        logic       b;
        logic [7:0] got;
        logic [7:0] exp;
        got = 8'h00;
        for (int i = 0; i < 8; i++) begin
            get_bit(b);
            got = {got[6:0], b};
        end
        put_bit(master_ack);
        exp = (exp_rd_q.size() > 0) ? exp_rd_q.pop_front() : 8'hxx;
        check(name, got, exp);
        $display("rd observed byte=0x%02h", got);
    endtask

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 8'h00;
        ram[8'h20] = 8'h5A;
        ram[8'h21] = 8'hC3;

        // Reset state
        repeat (5) @(negedge clk);
        check("rst_sda_t", {7'd0, sda_t}, 8'h01);
        check("rst_wr", {7'd0, wr}, 8'h00);
        check("rst_addr", addr, 8'h00);
        check("rst_data_out", data_out, 8'h00);
        check("rst_busy", {7'd0, busy}, 8'h00);
        reset = 1'b0;
        qwait();
        $display("txn reset checked");

        // Single write
        exp_wr_q.push_back('{a: 8'h10, d: 8'hA5});
        bus_start();
        send_byte(8'h84, 1'b0, "w1_dev_ack");
        check("w1_busy", {7'd0, busy}, 8'h01);
        send_byte(8'h10, 1'b0, "w1_ptr_ack");
        send_byte(8'hA5, 1'b0, "w1_data_ack");
        bus_stop();
        check("w1_busy_end", {7'd0, busy}, 8'h00);
        check("w1_addr_end", addr, 8'h11);
        check("w1_pending", 8'(exp_wr_q.size()), 8'd0);
        $display("txn write1 done");

        // Burst write with pointer wrap
        exp_wr_q.push_back('{a: 8'hFE, d: 8'h11});
        exp_wr_q.push_back('{a: 8'hFF, d: 8'h22});
        exp_wr_q.push_back('{a: 8'h00, d: 8'h33});
        bus_start();
        send_byte(8'h84, 1'b0, "bw_dev_ack");
        send_byte(8'hFE, 1'b0, "bw_ptr_ack");
        send_byte(8'h11, 1'b0, "bw_d0_ack");
        send_byte(8'h22, 1'b0, "bw_d1_ack");
        send_byte(8'h33, 1'b0, "bw_d2_ack");
        bus_stop();
        check("bw_addr_end", addr, 8'h01);
        check("bw_pending", 8'(exp_wr_q.size()), 8'd0);
        $display("txn burst write done");

        // Random read with repeated START
        exp_rd_q.push_back(8'h5A);
        exp_rd_q.push_back(8'hC3);
        bus_start();
        send_byte(8'h84, 1'b0, "rd_dev_ack");
        send_byte(8'h20, 1'b0, "rd_ptr_ack");
        bus_start();
        send_byte(8'h85, 1'b0, "rd_devr_ack");
        recv_byte(1'b0, "rd_byte0");
        recv_byte(1'b1, "rd_byte1");
        check("rd_busy_nack", {7'd0, busy}, 8'h00);
        bus_stop();
        check("rd_addr_end", addr, 8'h21);
        $display("txn random read done");

        // Foreign address: SDA must never be driven
        begin
            int snap;
            snap = drive_cnt;
            bus_start();
            send_byte(8'h90, 1'b1, "fa_dev_nack");
            check("fa_busy", {7'd0, busy}, 8'h00);
            send_byte(8'h00, 1'b1, "fa_ptr_nack");
            bus_stop();
            check("fa_sda_driven", {7'd0, (drive_cnt != snap)}, 8'h00);
            check("fa_busy_end", {7'd0, busy}, 8'h00);
        end
        $display("txn foreign address done");

        // Aborted data byte
        bus_start();
        send_byte(8'h84, 1'b0, "ab_dev_ack");
        send_byte(8'h30, 1'b0, "ab_ptr_ack");
        put_bit(1'b1);
        put_bit(1'b0);
        put_bit(1'b1);
        put_bit(1'b1);
        bus_stop();
        check("ab_addr", addr, 8'h30);
        check("ab_sda_t", {7'd0, sda_t}, 8'h01);
        check("ab_busy", {7'd0, busy}, 8'h00);
        check("ab_pending", 8'(exp_wr_q.size()), 8'd0);
        $display("txn aborted byte done");

        // Reset while the target is driving a 0 data bit
        bus_start();
        send_byte(8'h84, 1'b0, "rr_dev_ack");
        send_byte(8'h20, 1'b0, "rr_ptr_ack");
        bus_start();
        send_byte(8'h85, 1'b0, "rr_devr_ack");
        check("rr_drive0", {7'd0, sda_t}, 8'h00);
        check("rr_busy", {7'd0, busy}, 8'h01);
        reset = 1'b1;
        @(negedge clk);
        check("rr_sda_release", {7'd0, sda_t}, 8'h01);
        check("rr_busy_clear", {7'd0, busy}, 8'h00);
        reset = 1'b0;
        bus_stop();
        exp_wr_q.push_back('{a: 8'h40, d: 8'h77});
        bus_start();
        send_byte(8'h84, 1'b0, "rw_dev_ack");
        send_byte(8'h40, 1'b0, "rw_ptr_ack");
        send_byte(8'h77, 1'b0, "rw_data_ack");
        bus_stop();
        check("rw_addr_end", addr, 8'h41);
        check("rw_pending", 8'(exp_wr_q.size()), 8'd0);
        $display("txn reset during read done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_reg_slave.md
Name: i2c_reg_slave

Overview:
- I2C target (responder) that lets the ESP32 I2C master read and write a byte-addressed register window inside the FPGA.
- Protocol: standard "device address, register pointer, data..." transactions, the same ones the ESP32 issues to the RTC across the I2C bridge.
- SDA uses the bridge's open-drain convention: t=1 releases the line, t=0 pulls it low.
- The register side mirrors the existing SPI slave: wr strobe, addr, data_in, data_out.

Parameters:
- c_dev_addr, 7'h42, 7-bit device address the block answers to.
- c_addr_bits, 8, width of register pointer/addr.
- c_sync_stages, 3, input synchronizer depth for scl/sda (minimum 2).

Ports:
- clk  input  1  system clock (25 MHz nominal).
- reset  input  1  synchronous, active-high reset.
- scl_i  input  1  SCL pad level (asynchronous).
- sda_i  input  1  SDA pad level (asynchronous).
- sda_t  output  1  1 = release SDA (hi-Z), 0 = drive 0.
- wr  output  1  one-clk write strobe.
- addr  output  c_addr_bits  register pointer.
- data_in  input  8  read data for addr (registered RAM, valid 1 clk after addr).
- data_out  output  8  write data, valid while wr=1.
- busy  output  1  1 from a START addressed to us until STOP or NACK.

Behaviour:
- Reset values: sda_t=1, wr=0, addr=0, data_out=0, busy=0, state=IDLE.
- Inputs are synchronized through c_sync_stages flops. SCL edges are detected from the last two synced samples.
- START: SDA falls while SCL=1. STOP: SDA rises while SCL=1.
- START (including repeated START) from any state → ADDR, bit counter=0, sda_t=1.
- STOP from any state → IDLE, sda_t=1, busy=0.
- SDA is sampled on SCL rising edges; sda_t changes only on SCL falling edges plus 1 clk.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
- ADDR: shift 8 bits MSB-first.
  - If addr[7:1]==c_dev_addr: go to ADDR_ACK, drive sda_t=0 for one SCL period, busy=1.
  - Otherwise: go to IDLE and never drive SDA.
- After ADDR_ACK:
  - R/W=0 → PTR.
  - R/W=1 → RDATA. The shift register loads data_in at the SCL fall ending ACK, and the first bit is driven.
- PTR: 8 bits shifted in. On the 8th rising edge, addr ← received byte. Then PTR_ACK (drive 0), then WDATA.
- WDATA: 8 bits shifted in. On the 8th rising edge, data_out ← byte and wr=1 for exactly 1 clk. Then WDATA_ACK (drive 0).
- addr increments by 1 at the SCL fall ending WDATA_ACK.
- After WDATA_ACK → WDATA. The next START or STOP terminates the transfer.
- RDATA:
  - A 0 bit drives sda_t=0; a 1 bit releases the line.
  - After 8 bits, release SDA for RDATA_ACK and sample the master's ACK on the SCL rise.
  - ACK (0): addr increments at that rise. At the following SCL fall, reload from data_in → RDATA.
  - NACK (1): release SDA → IDLE, busy=0, addr not incremented.
- Wrap-around: addr wraps modulo 2^c_addr_bits, silently.
- A STOP in mid-byte discards the partial byte: no wr, addr unchanged.
- Reset mid-transaction releases SDA on the next clk.
- SDA changing at the same clk as an SCL edge: treat it as data, not START/STOP. START/STOP are checked only while SCL stays high.
- Throughput: SCL period must be ≥ 16 clk (standard/fast mode at 25 MHz is fine). Faster SCL is unsupported.

Decomposition:
- Shared package holds state encoding (enum/localparams for the 9 states), the ACK/NACK constants, and the release/drive constants for sda_t (1/0).
- One natural sub-module: i2c_line_sync. It synchronizes scl/sda and emits scl_rise, scl_fall, start, and stop one-clk pulses.

Test Plan:
- Write 1: START, 0x84 (0x42<<1|W), 0x10, 0xA5, STOP → three ACKs; wr pulses once with addr=0x10, data_out=0xA5.
- Burst write: START, 0x84, 0xFE, 0x11, 0x22, 0x33, STOP → wr at addr 0xFE, 0xFF, 0x00 (wrap) with data 0x11/0x22/0x33.
- Random read: model RAM with ram[0x20]=0x5A and ram[0x21]=0xC3. Sequence: START, 0x84, 0x20, repeated START, 0x85, master ACK, master NACK, STOP → SDA bytes are 0x5A then 0xC3; final addr=0x21; busy=0 after NACK.
- Foreign address: START, 0x90, 0x00, STOP → sda_t stays 1 for the whole transaction; no wr; busy stays 0.
- Aborted byte: START, 0x84, 0x30, 4 data bits, STOP → no wr; addr=0x30; state IDLE, sda_t=1.
- Reset during a read: assert reset while driving a 0 bit → sda_t=1 and busy=0 the next clk; a following valid write succeeds.
